// File: rtl/ov_cam_pkg.sv
// Purpose : shared definitions for the OV7670 RGB444 capture front end
//           (capture FSM states, pixel/coordinate widths, default frame size).
// Ports   : none (package).
package ov_cam_pkg;

  // Capture FSM: discard settling frames, wait for a frame start, capture one frame.
  typedef enum logic [1:0] {
    ST_SKIP   = 2'd0,
    ST_ARMED  = 2'd1,
    ST_ACTIVE = 2'd2
  } cap_state_t;

  // RGB444 field layout: {R[3:0], G[3:0], B[3:0]}.
  localparam int CH_W  = 4;
  localparam int PIX_W = 3 * CH_W;

  // Coordinate widths sized for the default 640x480 frame.
  localparam int X_W = 10;
  localparam int Y_W = 9;

  localparam int H_ACTIVE_DEF = 640;
  localparam int V_ACTIVE_DEF = 480;

  function automatic logic [PIX_W-1:0] pack_rgb444(
    input logic [CH_W-1:0] r,
    input logic [CH_W-1:0] g,
    input logic [CH_W-1:0] b
  );
    return {r, g, b};
  endfunction

endpackage

// File: rtl/sync_edge_det.sv
// Purpose : keeps a one-cycle-old copy of a level and flags its edges.
// Ports   : clk, reset_n (async, active-low), d (level in),
//           rise/fall (combinational one-cycle pulses in the cycle d differs from its old copy).
module sync_edge_det (
  input  logic clk,
  input  logic reset_n,
  input  logic d,
  output logic rise,
  output logic fall
);

  logic q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      q <= 1'b0;
    end else begin
      q <= d;
    end
  end

  assign rise = d & ~q;
  assign fall = ~d & q;

endmodule

// File: rtl/ov_capture_rgb444.sv
// Purpose : OV7670 DVP capture; pairs RGB444 bytes into 12-bit pixels with x/y coordinates,
//           skips settling frames after reset, frames on VSYNC, flags malformed lines/frames.
// Latency : second byte of a pixel presented in cycle n -> out_rgb/out_clken in cycle n+2;
//           out_href/out_vsync carry the same two-cycle delay.
// Backpressure: none; downstream must take every out_clken strobe.
// Ports   : clk (PCLK), reset_n (async, active-low), capture_en (level, sampled at frame start),
//           cam_vsync/cam_href/cam_data (camera bus), out_rgb/out_clken/out_href/out_vsync (pixel stream),
//           pix_x/pix_y (coordinates of out_rgb), frame_done (pulse at end of a captured frame),
//           fmt_err (sticky malformed-input flag).
module ov_capture_rgb444
  import ov_cam_pkg::*;
#(
  parameter int H_ACTIVE    = H_ACTIVE_DEF,
  parameter int V_ACTIVE    = V_ACTIVE_DEF,
  parameter int SKIP_FRAMES = 10
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             capture_en,
  input  logic             cam_vsync,
  input  logic             cam_href,
  input  logic [7:0]       cam_data,
  output logic [PIX_W-1:0] out_rgb,
  output logic             out_clken,
  output logic             out_href,
  output logic             out_vsync,
  output logic [X_W-1:0]   pix_x,
  output logic [Y_W-1:0]   pix_y,
  output logic             frame_done,
  output logic             fmt_err
);

  localparam int SKIP_W = (SKIP_FRAMES > 1) ? $clog2(SKIP_FRAMES + 1) : 1;
  localparam logic [SKIP_W-1:0] SKIP_TGT = SKIP_W'(SKIP_FRAMES);
  localparam logic [X_W-1:0]    X_LIM    = X_W'(H_ACTIVE);
  localparam logic [Y_W-1:0]    Y_LIM    = Y_W'(V_ACTIVE);

  // Input stage
  logic       s1_vsync;
  logic       s1_href;
  logic [7:0] s1_data;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      s1_vsync <= 1'b0;
      s1_href  <= 1'b0;
      s1_data  <= '0;
    end else begin
      s1_vsync <= cam_vsync;
      s1_href  <= cam_href;
      s1_data  <= cam_data;
    end
  end

  logic vs_rise, vs_fall;
  logic hr_rise, hr_fall;

  sync_edge_det u_vs_edge (
    .clk     (clk),
    .reset_n (reset_n),
    .d       (s1_vsync),
    .rise    (vs_rise),
    .fall    (vs_fall)
  );

  sync_edge_det u_hr_edge (
    .clk     (clk),
    .reset_n (reset_n),
    .d       (s1_href),
    .rise    (hr_rise),
    .fall    (hr_fall)
  );

  // Capture FSM
  cap_state_t          state, state_nxt;
  logic [SKIP_W-1:0]   skip_cnt;
  logic                skip_done;

  assign skip_done = (skip_cnt == SKIP_TGT);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= ST_SKIP;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_SKIP: begin
        if (skip_done) state_nxt = ST_ARMED;
      end
      ST_ARMED: begin
        // capture_en only matters here, so a mid-frame change waits for the next start.
        if (vs_fall && capture_en) state_nxt = ST_ACTIVE;
      end
      ST_ACTIVE: begin
        if (vs_rise) state_nxt = ST_ARMED;
      end
      default: state_nxt = ST_SKIP;
    endcase
  end

  // Settling-frame counter stops at its target so it never wraps.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      skip_cnt <= '0;
    end else if (state == ST_SKIP && vs_fall && !skip_done) begin
      skip_cnt <= skip_cnt + 1'b1;
    end
  end

  // Byte pairing
  logic             in_active;
  logic             phase;       // 1 = red nibble latched, waiting for the G/B byte
  logic             phase_eff;
  logic [CH_W-1:0]  r_lat;
  logic             byte_vld;
  logic             pair_done;
  logic             x_full;
  logic             y_full;
  logic             strobe;
  logic             overflow;
  logic             odd_end;
  logic [X_W-1:0]   x_cnt;
  logic [Y_W-1:0]   y_cnt;

  assign in_active = (state == ST_ACTIVE);
  // A VSYNC rise aborts the line, so a byte arriving with it is not paired.
  assign byte_vld  = in_active && s1_href && !vs_rise;
  // Every line restarts on an R byte, whatever the previous line left behind.
  assign phase_eff = hr_rise ? 1'b0 : phase;
  assign pair_done = byte_vld && phase_eff;
  assign x_full    = (x_cnt >= X_LIM);
  assign y_full    = (y_cnt >= Y_LIM);
  assign strobe    = pair_done && !x_full && !y_full;
  assign overflow  = pair_done && (x_full || y_full);
  assign odd_end   = in_active && hr_fall && phase;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      phase <= 1'b0;
      r_lat <= '0;
    end else begin
      if (!in_active || vs_rise || hr_fall) begin
        phase <= 1'b0;
      end else if (byte_vld) begin
        phase <= ~phase_eff;
      end
      if (byte_vld && !phase_eff) begin
        r_lat <= s1_data[CH_W-1:0];
      end
    end
  end

  // Coordinate counters: x_cnt/y_cnt point at the next pixel to be emitted.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      x_cnt <= '0;
      y_cnt <= '0;
    end else begin
      if (!in_active || hr_fall || vs_rise) begin
        x_cnt <= '0;
      end else if (strobe) begin
        x_cnt <= x_cnt + 1'b1;
      end

      // Lines that produced nothing (blank or fully suppressed) do not advance the row.
      if (vs_fall) begin
        y_cnt <= '0;
      end else if (in_active && hr_fall && (x_cnt != '0)) begin
        y_cnt <= y_cnt + 1'b1;
      end
    end
  end

  // Output stage
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      out_rgb    <= '0;
      out_clken  <= 1'b0;
      out_href   <= 1'b0;
      out_vsync  <= 1'b0;
      pix_x      <= '0;
      pix_y      <= '0;
      frame_done <= 1'b0;
      fmt_err    <= 1'b0;
    end else begin
      out_clken  <= strobe;
      out_href   <= s1_href;
      out_vsync  <= s1_vsync;
      frame_done <= in_active && vs_rise;
      if (strobe) begin
        out_rgb <= pack_rgb444(r_lat, s1_data[7:4], s1_data[3:0]);
        pix_x   <= x_cnt;
        pix_y   <= y_cnt;
      end
      if (odd_end || overflow) begin
        fmt_err <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_ov_capture_rgb444.sv
module tb_ov_capture_rgb444;

  localparam int H    = 4;
  localparam int V    = 3;
  localparam int SKIP = 2;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        capture_en = 1'b0;
  logic        cam_vsync = 1'b1;
  logic        cam_href = 1'b0;
  logic [7:0]  cam_data = 8'h00;
  logic [11:0] out_rgb;
  logic        out_clken;
  logic        out_href;
  logic        out_vsync;
  logic [9:0]  pix_x;
  logic [8:0]  pix_y;
  logic        frame_done;
  logic        fmt_err;

  ov_capture_rgb444 #(
    .H_ACTIVE    (H),
    .V_ACTIVE    (V),
    .SKIP_FRAMES (SKIP)
  ) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .capture_en (capture_en),
    .cam_vsync  (cam_vsync),
    .cam_href   (cam_href),
    .cam_data   (cam_data),
    .out_rgb    (out_rgb),
    .out_clken  (out_clken),
    .out_href   (out_href),
    .out_vsync  (out_vsync),
    .pix_x      (pix_x),
    .pix_y      (pix_y),
    .frame_done (frame_done),
    .fmt_err    (fmt_err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [11:0] rgb;
    logic [9:0]  x;
    logic [8:0]  y;
    int          cyc;
    logic [1:0]  hv;
  } pix_t;

  pix_t       obs_q[$];
  int         fd_count = 0;
  int         fd_wide = 0;
  bit         fd_prev = 1'b0;

  logic [7:0] fb[$];
  int         fc[$];
  logic [7:0] pend[$];
  int         plan[$];
  int         skip_left;
  bit         merr;

  int checks = 0;
  int errors = 0;

  // Monitor: sample outputs on the falling edge, away from the DUT's active edge.
  always @(negedge clk) begin
    pix_t p;
    if (out_clken === 1'b1) begin
      p.rgb = out_rgb;
      p.x   = pix_x;
      p.y   = pix_y;
      p.cyc = cyc;
      p.hv  = {out_href, out_vsync};
      obs_q.push_back(p);
    end
    if (frame_done === 1'b1) begin
      fd_count++;
      if (fd_prev) fd_wide++;
    end
    fd_prev = (frame_done === 1'b1);
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_zero(input string tag);
    check({tag, " out_rgb"},    32'(out_rgb),    32'h0);
    check({tag, " out_clken"},  32'(out_clken),  32'h0);
    check({tag, " out_href"},   32'(out_href),   32'h0);
    check({tag, " out_vsync"},  32'(out_vsync),  32'h0);
    check({tag, " pix_x"},      32'(pix_x),      32'h0);
    check({tag, " pix_y"},      32'(pix_y),      32'h0);
    check({tag, " frame_done"}, 32'(frame_done), 32'h0);
    check({tag, " fmt_err"},    32'(fmt_err),    32'h0);
  endtask

  function automatic logic [31:0] obs_field(input int i, input int which);
    if (i >= obs_q.size()) return 32'hDEAD_BEEF;
    case (which)
      0:       return 32'(obs_q[i].rgb);
      1:       return 32'(obs_q[i].x);
      default: return 32'(obs_q[i].y);
    endcase
  endfunction

  task automatic drive_bytes(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      cam_href = 1'b1;
      if (pend.size() > 0) cam_data = pend.pop_front();
      else                 cam_data = 8'($urandom_range(0, 255));
      fb.push_back(cam_data);
      fc.push_back(cyc);
    end
  endtask

  // One VSYNC-framed frame built from plan[] (bytes per line), then compared against the model.
  task automatic run_frame(input string tag, input bit ce, input bit raise_mid, input bit abort_last);
    pix_t       e;
    pix_t       ex[$];
    bit         cap;
    int         k, y, n, em, fd0;
    logic [7:0] b0, b1;
    fb.delete();
    fc.delete();
    obs_q.delete();
    fd0 = fd_count;
    @(negedge clk);
    capture_en = ce;
    @(negedge clk);
    cam_vsync = 1'b0;
    repeat (3) @(negedge clk);
    foreach (plan[li]) begin
      drive_bytes(plan[li]);
      if (abort_last && li == plan.size() - 1) begin
        @(negedge clk);
        cam_vsync = 1'b1;
        cam_data  = 8'hFF;
        @(negedge clk);
        cam_href = 1'b0;
      end else begin
        @(negedge clk);
        cam_href = 1'b0;
        repeat (2) @(negedge clk);
        if (raise_mid && li == 0) capture_en = 1'b1;
      end
    end
    if (!abort_last) begin
      @(negedge clk);
      cam_vsync = 1'b1;
    end
    repeat (6) @(negedge clk);

    // Reference: which frames are captured, and which byte pairs survive the limits.
    if (skip_left > 0) begin
      skip_left--;
      cap = 1'b0;
    end else begin
      cap = ce;
    end
    k = 0;
    y = 0;
    foreach (plan[li]) begin
      n  = plan[li];
      em = 0;
      if (cap) begin
        if ((n % 2 == 1) && !(abort_last && li == plan.size() - 1)) merr = 1'b1;
        for (int p = 0; p < n / 2; p++) begin
          if (y >= V || p >= H) begin
            merr = 1'b1;
          end else begin
            b0    = fb[k + 2 * p];
            b1    = fb[k + 2 * p + 1];
            e.rgb = {b0[3:0], b1};
            e.x   = 10'(p);
            e.y   = 9'(y);
            e.cyc = fc[k + 2 * p + 1] + 2;
            e.hv  = 2'b10;
            ex.push_back(e);
            em++;
          end
        end
        if (em > 0) y++;
      end
      k += n;
    end

    check({tag, " npix"}, obs_q.size(), ex.size());
    for (int i = 0; i < obs_q.size() && i < ex.size(); i++) begin
      check($sformatf("%s px%0d rgb", tag, i),   32'(obs_q[i].rgb), 32'(ex[i].rgb));
      check($sformatf("%s px%0d x", tag, i),     32'(obs_q[i].x),   32'(ex[i].x));
      check($sformatf("%s px%0d y", tag, i),     32'(obs_q[i].y),   32'(ex[i].y));
      check($sformatf("%s px%0d cycle", tag, i), obs_q[i].cyc,      ex[i].cyc);
      check($sformatf("%s px%0d href/vs", tag, i), 32'(obs_q[i].hv), 32'(ex[i].hv));
    end
    check({tag, " frame_done"}, fd_count - fd0, 32'(cap));
    check({tag, " fmt_err"}, 32'(fmt_err), 32'(merr));
  endtask

  initial begin
    skip_left = SKIP;
    merr      = 1'b0;

    // Reset state
    repeat (3) @(negedge clk);
    check_zero("reset");
    @(negedge clk);
    reset_n = 1'b1;

    // Settling frames are discarded, the third frame is captured
    plan = '{4, 4};
    run_frame("skip1", 1'b1, 1'b0, 1'b0);
    run_frame("skip2", 1'b1, 1'b0, 1'b0);
    run_frame("first", 1'b1, 1'b0, 1'b0);

    // Directed pair of pixels
    pend = '{8'h0A, 8'hBC, 8'h05, 8'h6F};
    plan = '{4};
    run_frame("pair", 1'b1, 1'b0, 1'b0);
    check("pair rgb0 const", obs_field(0, 0), 32'hABC);
    check("pair rgb1 const", obs_field(1, 0), 32'h56F);
    check("pair x1 const",   obs_field(1, 1), 32'd1);

    // Random well-formed frames
    for (int f = 0; f < 4; f++) begin
      plan.delete();
      repeat ($urandom_range(1, 3)) plan.push_back(2 * $urandom_range(1, 4));
      run_frame($sformatf("clean%0d", f), 1'b1, 1'b0, 1'b0);
    end

    // capture_en low at frame start, raised mid-frame; next frame captured
    plan = '{4, 4, 4};
    run_frame("ce_off", 1'b0, 1'b1, 1'b0);
    plan = '{6};
    run_frame("ce_next", 1'b1, 1'b0, 1'b0);

    // Odd byte count line
    pend = '{8'h01, 8'h23, 8'h04};
    plan = '{3, 4};
    run_frame("odd", 1'b1, 1'b0, 1'b0);
    check("odd rgb0 const", obs_field(0, 0), 32'h123);
    check("odd next x0",    obs_field(1, 1), 32'd0);
    check("odd next y1",    obs_field(1, 2), 32'd1);

    // Over-length lines, then too many lines
    plan = '{12, 12};
    run_frame("hlimit", 1'b1, 1'b0, 1'b0);
    plan = '{2, 4, 2, 2};
    run_frame("vlimit", 1'b1, 1'b0, 1'b0);

    // Random, possibly malformed frames
    for (int f = 0; f < 3; f++) begin
      plan.delete();
      repeat ($urandom_range(1, 4)) plan.push_back($urandom_range(1, 12));
      run_frame($sformatf("messy%0d", f), 1'b1, 1'b0, 1'b0);
    end

    // Asynchronous reset mid-line after an odd byte
    @(negedge clk);
    cam_vsync = 1'b0;
    repeat (3) @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      cam_href = 1'b1;
      cam_data = 8'($urandom_range(0, 255));
    end
    @(negedge clk);
    reset_n = 1'b0;
    #1;
    check_zero("async rst");
    @(negedge clk);
    cam_href = 1'b0;
    repeat (2) @(negedge clk);
    obs_q.delete();
    reset_n = 1'b1;
    repeat (3) @(negedge clk);
    cam_vsync = 1'b1;
    repeat (4) @(negedge clk);
    check("post-rst no strobe", obs_q.size(), 32'd0);
    skip_left = SKIP;
    merr      = 1'b0;

    plan = '{4, 6};
    run_frame("rskip1", 1'b1, 1'b0, 1'b0);
    run_frame("rskip2", 1'b1, 1'b0, 1'b0);
    run_frame("rfirst", 1'b1, 1'b0, 1'b0);

    // VSYNC rising mid-line after an odd byte: line aborted, no format error
    plan = '{4, 3};
    run_frame("abort", 1'b1, 1'b0, 1'b1);
    plan = '{4, 2};
    run_frame("after_abort", 1'b1, 1'b0, 1'b0);

    check("frame_done width", fd_wide, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
